// File: rtl/noc_pkg.sv
// noc_pkg: shared flit type, default sizes and arbiter state encoding for
// the NoC client injection port.
package noc_pkg;

    localparam int VC_W_DEF       = 3;
    localparam int X_W_DEF        = 2;
    localparam int Y_W_DEF        = 2;
    localparam int D_W_DEF        = 1;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int NVC   = 1 << VC_W_DEF;
    localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);

    // One buffered flit; the VC id is implied by the FIFO it sits in.
    typedef struct packed {
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
        logic [D_W_DEF-1:0] data;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: per-VC flit FIFO with registered occupancy.
// Exposes the head and the entry behind it so the arbiter can present the
// next flit of the same VC in the cycle the current head is popped.
module noc_vc_fifo
    import noc_pkg::*;
#(
    parameter int AW = PTR_W
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    input  flit_t din_i,
    output flit_t head_o,
    output flit_t head2_o,
    output logic  full_o,
    output logic  empty_o,
    output logic  last_o
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    flit_t          mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_nxt;
    logic [CW-1:0]  cnt_q;

    // Storage array holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rd_nxt  = rd_ptr_q + AW'(1);
    assign head_o  = mem_q[rd_ptr_q];
    assign head2_o = mem_q[rd_nxt];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign last_o  = (cnt_q == CW'(1));

endmodule

// File: rtl/noc_inject_port.sv
// noc_inject_port: router-side end of the client injection link.
// Acks client flits into one FIFO per VC and round-robin arbitrates the
// FIFOs onto a registered valid/ready link toward the router core.
// Optional build macro INJ_STATS_EN adds acc_cnt, fwd_cnt and stall outputs.
// Flit field widths come from noc_pkg; parameter overrides must agree with it.
module noc_inject_port
    import noc_pkg::*;
#(
    parameter int VC_W       = VC_W_DEF,
    parameter int X_W        = X_W_DEF,
    parameter int Y_W        = Y_W_DEF,
    parameter int D_W        = D_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_v,
    input  logic [VC_W-1:0] i_vc,
    input  logic [X_W-1:0]  i_x,
    input  logic [Y_W-1:0]  i_y,
    input  logic [D_W-1:0]  i_data,
    output logic            i_ack,
    output logic            o_v,
    input  logic            o_rdy,
    output logic [VC_W-1:0] o_vc,
    output logic [X_W-1:0]  o_x,
    output logic [Y_W-1:0]  o_y,
    output logic [D_W-1:0]  o_data
`ifdef INJ_STATS_EN
    ,
    output logic [31:0]     acc_cnt,
    output logic [31:0]     fwd_cnt,
    output logic            stall
`endif
);

    flit_t           in_flit;
    logic [NVC-1:0]  full;
    logic [NVC-1:0]  empty;
    logic [NVC-1:0]  last;
    logic [NVC-1:0]  push;
    logic [NVC-1:0]  pop;
    logic [NVC-1:0]  avail;
    flit_t           head  [NVC];
    flit_t           head2 [NVC];

    arb_state_e      state_q;
    logic [VC_W-1:0] rr_q;
    logic [VC_W-1:0] grant_q;
    logic            o_v_q;
    logic [VC_W-1:0] o_vc_q;
    flit_t           o_flit_q;

    logic            do_pop;
    logic            found;
    logic [VC_W-1:0] base;
    logic [VC_W-1:0] idx;
    logic [VC_W-1:0] grant_d;
    flit_t           head_d;

    assign in_flit = {i_x, i_y, i_data};

    // Acceptance looks only at registered fullness: no same-cycle pop bypass.
    assign i_ack = !rst && i_v && !full[i_vc];

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        noc_vc_fifo #(
            .AW($clog2(FIFO_DEPTH))
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .din_i   (in_flit),
            .head_o  (head[v]),
            .head2_o (head2[v]),
            .full_o  (full[v]),
            .empty_o (empty[v]),
            .last_o  (last[v])
        );
    end

    // Push/pop decode and round-robin pick over the occupancy left after this cycle's pop.
    always_comb begin
        push    = '0;
        pop     = '0;
        do_pop  = (state_q == LOCK) && o_rdy;
        if (i_ack) begin
            push[i_vc] = 1'b1;
        end
        if (do_pop) begin
            pop[grant_q] = 1'b1;
        end
        avail   = ~empty & ~(pop & last);
        base    = do_pop ? (grant_q + VC_W'(1)) : rr_q;
        found   = 1'b0;
        grant_d = base;
        idx     = '0;
        // Scan from farthest to nearest so the nearest candidate wins.
        for (int k = NVC - 1; k >= 0; k--) begin
            idx = base + VC_W'(k);
            if (avail[idx]) begin
                found   = 1'b1;
                grant_d = idx;
            end
        end
        // A VC popped this cycle presents the entry behind its current head.
        head_d = pop[grant_d] ? head2[grant_d] : head[grant_d];
    end

    // Arbiter FSM with the registered output stage toward the router core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            o_v_q    <= 1'b0;
            o_vc_q   <= '0;
            o_flit_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q  <= grant_d;
                        o_v_q    <= 1'b1;
                        o_vc_q   <= grant_d;
                        o_flit_q <= head_d;
                        state_q  <= LOCK;
                    end
                end
                LOCK: begin
                    if (o_rdy) begin
                        rr_q <= grant_q + VC_W'(1);
                        if (found) begin
                            grant_q  <= grant_d;
                            o_vc_q   <= grant_d;
                            o_flit_q <= head_d;
                        end else begin
                            o_v_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_v    = o_v_q;
    assign o_vc   = o_vc_q;
    assign o_x    = o_flit_q.x;
    assign o_y    = o_flit_q.y;
    assign o_data = o_flit_q.data;

`ifdef INJ_STATS_EN
    logic [31:0] acc_cnt_q;
    logic [31:0] fwd_cnt_q;

    // Free-running accept/forward counters that wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (i_ack) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if (o_v_q && o_rdy) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign acc_cnt = acc_cnt_q;
    assign fwd_cnt = fwd_cnt_q;
    assign stall   = i_v && !i_ack;
`endif

endmodule
